// File: rtl/hba_reset_ctrl_if.sv
// hba_reset_ctrl_if: board-side reset requests into the sequencer and per-domain resets out of it.
// master = board/PLL side driving the requests, slave = the reset controller.
interface hba_reset_ctrl_if #(
  parameter int unsigned NUM_DOMAINS = 2
);
  logic                   pll_locked;
  logic                   ext_rst_n;
  logic                   sw_rst_req;
  logic [NUM_DOMAINS-1:0] rst_out;
  logic                   ready;
  logic [1:0]             rst_cause;

  modport master (
    output pll_locked, ext_rst_n, sw_rst_req,
    input  rst_out, ready, rst_cause
  );

  modport slave (
    input  pll_locked, ext_rst_n, sw_rst_req,
    output rst_out, ready, rst_cause
  );
endinterface

// File: rtl/hba_reset_ctrl.sv
// hba_reset_ctrl: PLL-lock qualified reset sequencer with staggered per-domain release.
// Define HBA_RSTCTL_DEBOUNCE_EN to build the external-button debouncer.
module hba_reset_ctrl #(
  parameter int unsigned NUM_DOMAINS     = 2,
  parameter int unsigned HOLD_CYCLES     = 10,
  parameter int unsigned STAGGER_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input logic             clk,
  input logic             reset,
  hba_reset_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_EXT  = 2'd2;
  localparam logic [1:0] CAUSE_SW   = 2'd3;

  // Reject parameter sets the counters cannot represent.
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 ||
      DEBOUNCE_CYCLES < 2 || ((HOLD_CYCLES - 1) >> CNT_WIDTH) != 0 ||
      ((STAGGER_CYCLES - 1) >> CNT_WIDTH) != 0 ||
      ((DEBOUNCE_CYCLES - 1) >> CNT_WIDTH) != 0) begin : g_bad_params
    $error("hba_reset_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  // Two-stage synchronizers; the button idles released so reset never looks like a press.
  logic [1:0] lock_sync;
  logic [1:0] btn_sync;
  logic       lock_s;
  logic       btn_s;
  logic       btn_pressed;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sync <= 2'b00;
      btn_sync  <= 2'b11;
    end else begin
      lock_sync <= {lock_sync[0], bus.pll_locked};
      btn_sync  <= {btn_sync[0], bus.ext_rst_n};
    end
  end

  assign lock_s = lock_sync[1];
  assign btn_s  = btn_sync[1];

`ifdef HBA_RSTCTL_DEBOUNCE_EN
  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] deb_cnt;

  // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_pressed <= 1'b0;
      deb_cnt     <= '0;
    end else if (~btn_s == btn_pressed) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_pressed <= ~btn_s;
      deb_cnt     <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign btn_pressed = ~btn_s;
`endif

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_nxt;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    idx_nxt = idx_q + IDX_W'(1);

    case (state_q)
      S_WAIT_LOCK: begin
        rst_d   = '1;
        ready_d = 1'b0;
        if (lock_s) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d  = S_RELEASE;
          cnt_d    = '0;
          idx_d    = '0;
          rst_d[0] = 1'b0;
          // A single domain has nothing to stagger.
          if (NUM_DOMAINS == 1) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_RELEASE: begin
        if (cnt_q == STAG_LAST) begin
          cnt_d = '0;
          idx_d = idx_nxt;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (IDX_W'(i) == idx_nxt) rst_d[i] = 1'b0;
          end
          if (idx_nxt == IDX_LAST) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_RUN: begin
      end
      default: begin
        state_d = S_WAIT_LOCK;
        rst_d   = '1;
        ready_d = 1'b0;
      end
    endcase

    // Re-entry triggers override the sequencing above; only the highest one is taken.
    if (state_q != S_WAIT_LOCK) begin
      if (!lock_s) begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '1;
        ready_d = 1'b0;
        cause_d = CAUSE_LOCK;
      end else if (btn_pressed) begin
        state_d = S_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '1;
        ready_d = 1'b0;
        cause_d = CAUSE_EXT;
      end else if (bus.sw_rst_req) begin
        state_d = S_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '1;
        ready_d = 1'b0;
        cause_d = CAUSE_SW;
      end
    end
  end

  assign bus.rst_out   = rst_q;
  assign bus.ready     = ready_q;
  assign bus.rst_cause = cause_q;

endmodule

// File: doc/hba_reset_ctrl.md
# hba_reset_ctrl

Parametrised reset sequencer for HBA board top levels, replacing the fixed power-up hold counter. Qualifies the PLL lock, holds reset for a programmable time, releases up to N reset domains in a staggered order, and re-enters reset on lock loss, an external button, or a software request. Sits between the PLL and `hba_system` (and any other clocked domains) in every board top.

## Interface
- `NUM_DOMAINS`, 2: number of reset outputs, 1..8.
- `HOLD_CYCLES`, 10: cycles reset is held after lock is qualified, ≥1.
- `STAGGER_CYCLES`, 4: cycles between successive domain releases, ≥1.
- `DEBOUNCE_CYCLES`, 16: stable cycles required on the external button, ≥2.
- `CNT_WIDTH`, 16: width of the shared hold/stagger/debounce counters. Must hold the largest of the three counts.

Ports:
- `clk`, in, 1: system clock (PLL output).
- `reset`, in, 1: synchronous, active-high; forces the power-on state.
- `pll_locked`, in, 1: PLL lock, asynchronous to `clk`.
- `ext_rst_n`, in, 1: external reset button, active-low, asynchronous.
- `sw_rst_req`, in, 1: single-cycle software reset request, synchronous.
- `rst_out`, out, NUM_DOMAINS: per-domain reset, active-high. Domain 0 is released first.
- `ready`, out, 1: all domains released.
- `rst_cause`, out, 2: cause of the last reset. 0 = POR, 1 = lock loss, 2 = external, 3 = software.

## Operation
- `pll_locked` and `ext_rst_n` each pass through a 2-FF synchronizer, giving `lock_s` and `btn_s`.
- While `reset`=1: `rst_out` is all ones, `ready`=0, `rst_cause`=0, state is WAIT_LOCK, and all counters are 0.
- States:
  - WAIT_LOCK: all `rst_out` are 1. When `lock_s`=1, go to HOLD with cnt=0.
  - HOLD: all `rst_out` are 1. cnt increments each cycle. When cnt reaches HOLD_CYCLES−1, go to RELEASE with idx=0 and cnt=0, and clear `rst_out[0]`.
  - RELEASE: cnt increments. When cnt reaches STAGGER_CYCLES−1, idx increments and `rst_out[idx]` clears. When the last domain clears, set `ready`=1 and go to RUN.
  - RUN: hold the outputs and watch the triggers.
- Triggers, in priority order (highest first), evaluated in every state except WAIT_LOCK:
  - `lock_s`=0: go to WAIT_LOCK, cause=1.
  - Debounced button press: go to HOLD with cnt=0, cause=2.
  - `sw_rst_req`=1: go to HOLD with cnt=0, cause=3.
- On any accepted trigger, on the next edge: all `rst_out` become 1 and `ready` becomes 0.
- `sw_rst_req` in WAIT_LOCK is ignored and does not change the cause.
- While the debounced button stays pressed, HOLD keeps cnt at 0. Counting starts after the debounced release.
- Simultaneous triggers: only the highest priority is taken. Lower ones are dropped, not queued.
- `rst_cause` changes only when a trigger is accepted and persists through RUN.

## Timing
- Lock qualification latency is 2 cycles from `pll_locked` rising to HOLD entry.
- `rst_out[0]` falls HOLD_CYCLES cycles after HOLD entry.
- `rst_out[i]` falls STAGGER_CYCLES cycles after `rst_out[i-1]`.
- `ready` rises on the same edge as `rst_out[NUM_DOMAINS-1]` falls.
- Lock loss reaches `rst_out` 3 cycles after `pll_locked` falls (2 sync + 1 register).
- Software request reaches `rst_out` 1 cycle after the `sw_rst_req` pulse.
- All outputs are registered, with no combinational path from inputs.
- With NUM_DOMAINS=1 there is no stagger: RELEASE ends on the cycle `rst_out[0]` falls.

## Configuration
- `HBA_RSTCTL_DEBOUNCE_EN` defined:
  - `btn_s` must be low for DEBOUNCE_CYCLES consecutive cycles to register a press.
  - It must be high for DEBOUNCE_CYCLES consecutive cycles to register a release.
  - Shorter glitches are ignored.
- Undefined:
  - `btn_s` is used directly: a press is `btn_s`=0 and acts after the 2-FF sync delay.
  - The debounce counter is not built.
  - DEBOUNCE_CYCLES is unused.

## Test plan
Default parameters throughout (N=2, HOLD=10, STAGGER=4, DEBOUNCE=16), with the macro defined.
- **POR:** `pll_locked`=1, `reset` released at cycle 0 → `rst_out[0]` falls at cycle 12, `rst_out[1]` falls at cycle 16, `ready`=1 at cycle 16, `rst_cause`=0.
- **Late lock:** `pll_locked` rises at cycle 50 → HOLD entered at cycle 52, `rst_out[0]` falls at cycle 62.
- **Lock loss in RUN:** `pll_locked` drops → `rst_out`=2'b11 and `ready`=0 three cycles later, `rst_cause`=1. The sequence reruns when lock returns.
- **Button:** a 10-cycle low glitch gives no effect. A 40-cycle low press gives reset asserted, `rst_cause`=2, and `rst_out[0]` falling 10 cycles after the debounced release.
- **Software:** `sw_rst_req` pulse in RUN → `rst_out`=2'b11 next cycle, `rst_cause`=3. A pulse during RELEASE restarts HOLD, and `rst_out[0]` reasserts.
- **Simultaneous:** `sw_rst_req` in the same cycle as the first `lock_s`=0 → `rst_cause`=1 and state is WAIT_LOCK. A `reset` pulse mid-RELEASE → all ones and `rst_cause`=0.
